// File: rtl/wb_shared_bus_if.sv
// rtl/wb_shared_bus_if.sv - Wishbone shared-bus signal bundle for NM masters and NS slaves
interface wb_shared_bus_if #(
    parameter int NM = 2,
    parameter int NS = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8
);
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic             s_we_o;
    logic [SW-1:0]    s_sel_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;
    logic [NS-1:0]    s_err_i;
    logic [NM-1:0]    grant_o;

    modport intercon (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o, grant_o
    );

    modport slave (
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_shared_bus.sv
// rtl/wb_shared_bus.sv - Wishbone B3 classic shared-bus interconnect
// Round-robin owner arbitration, mask/base slave decode, decode-miss and watchdog errors.
module wb_shared_bus #(
    parameter int             NM      = 2,
    parameter int             NS      = 3,
    parameter int             AW      = 32,
    parameter int             DW      = 32,
    parameter logic [NS*AW-1:0] S_BASE = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter int             TIMEOUT = 255
) (
    input logic               clk_i,
    input logic               rst_i,
    wb_shared_bus_if.intercon bus
);
    localparam int SW  = DW / 8;
    localparam int PW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int WDW = (TIMEOUT > 255) ? 16 : 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  rr_ptr;
    logic [NM-1:0]  grant;
    logic [WDW-1:0] wd_cnt;
    logic           decerr;

    logic [PW-1:0]  next_owner;
    logic           any_req;
    logic           o_cyc, o_stb, o_we;
    logic [SW-1:0]  o_sel;
    logic [AW-1:0]  o_adr;
    logic [DW-1:0]  o_dat;
    logic [NS-1:0]  hit;
    logic [SIW-1:0] sel;
    logic           any_hit;
    logic           wd_fire, stb_eff, sl_ack, sl_err, ack, err;
    logic [NM-1:0]  m_ack, m_err;

    // Scan from farthest to nearest so the first requester at/after rr_ptr wins.
    always_comb begin : pick_next
        int idx;
        idx        = 0;
        next_owner = rr_ptr;
        any_req    = 1'b0;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NM;
            if (bus.m_cyc_i[idx]) begin
                next_owner = PW'(idx);
                any_req    = 1'b1;
            end
        end
    end

    always_comb begin
        o_cyc = 1'b0;
        o_stb = 1'b0;
        o_we  = 1'b0;
        o_sel = '0;
        o_adr = '0;
        o_dat = '0;
        if (state == BUSY) begin
            o_cyc = bus.m_cyc_i[owner];
            o_stb = bus.m_stb_i[owner];
            o_we  = bus.m_we_i[owner];
            o_sel = bus.m_sel_i[owner*SW +: SW];
            o_adr = bus.m_adr_i[owner*AW +: AW];
            o_dat = bus.m_dat_i[owner*DW +: DW];
        end
    end

    always_comb begin
        sel     = '0;
        any_hit = 1'b0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((o_adr & S_MASK[k*AW +: AW]) == (S_BASE[k*AW +: AW] & S_MASK[k*AW +: AW])) begin
                sel     = SIW'(k);
                any_hit = 1'b1;
            end
        end
        if (state != BUSY) any_hit = 1'b0;
        hit      = '0;
        hit[sel] = any_hit;
    end

    assign wd_fire = (TIMEOUT != 0) && (state == BUSY) && o_stb && (wd_cnt == WDW'(TIMEOUT));
    assign stb_eff = o_stb & ~wd_fire;
    assign sl_ack  = any_hit & stb_eff & bus.s_ack_i[sel];
    assign sl_err  = any_hit & stb_eff & bus.s_err_i[sel];
    // A slave error outranks a simultaneous ack.
    assign err     = sl_err | wd_fire | (decerr & o_stb);
    assign ack     = sl_ack & ~err;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (state == BUSY) begin
            m_ack[owner] = ack;
            m_err[owner] = err;
        end
    end

    assign bus.m_ack_o = m_ack;
    assign bus.m_err_o = m_err;
    assign bus.m_dat_o = any_hit ? bus.s_dat_i[sel*DW +: DW] : '0;
    assign bus.s_cyc_o = {NS{o_cyc}} & hit;
    assign bus.s_stb_o = {NS{stb_eff}} & hit;
    assign bus.s_we_o  = o_we;
    assign bus.s_sel_o = o_sel;
    assign bus.s_adr_o = o_adr;
    assign bus.s_dat_o = o_dat;
    assign bus.grant_o = grant;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            grant  <= '0;
            wd_cnt <= '0;
            decerr <= 1'b0;
        end else begin
            decerr <= (state == BUSY) && o_cyc && o_stb && !any_hit && !decerr;
            if ((state != BUSY) || !o_stb || ack || err) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state             <= BUSY;
                        owner             <= next_owner;
                        grant             <= '0;
                        grant[next_owner] <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!o_cyc) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= (owner == PW'(NM - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// tb/tb_wb_shared_bus.sv - self-checking bench for wb_shared_bus against a behavioural model
module tb_wb_shared_bus;
    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;
    // S2 overlaps S0 and S1 so lowest-index priority gets exercised.
    localparam logic [NS*AW-1:0] SB = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] SM = {32'hFFFC_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wb_shared_bus_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

    wb_shared_bus #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW), .S_BASE(SB), .S_MASK(SM), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus(bus)
    );

    int own = -1;
    int rr = 0;
    int wd = 0;
    bit dec = 1'b0;

    logic [NM-1:0] e_grant, e_ack, e_err;
    logic [NS-1:0] e_cyc, e_stb;
    logic          e_we;
    logic [SW-1:0] e_sel;
    logic [31:0]   e_adr, e_wdat, e_rdat;
    bit            mc, ms, mer, mack;
    int            mslv;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        int slv;
        bit c, s, fire, serr, sack, er;
        logic [31:0] a;
        e_grant = '0; e_ack = '0; e_err = '0; e_cyc = '0; e_stb = '0;
        e_we = 1'b0; e_sel = '0; e_adr = '0; e_wdat = '0; e_rdat = '0;
        slv = -1; c = 0; s = 0; serr = 0; sack = 0; a = '0;
        if (own >= 0) begin
            c = bus.m_cyc_i[own];
            s = bus.m_stb_i[own];
            a = bus.m_adr_i[own*AW +: AW];
            e_we = bus.m_we_i[own];
            e_sel = bus.m_sel_i[own*SW +: SW];
            e_adr = a;
            e_wdat = bus.m_dat_i[own*DW +: DW];
            e_grant[own] = 1'b1;
            for (int k = 0; k < NS && slv < 0; k++)
                if ((a & SM[k*AW +: AW]) == (SB[k*AW +: AW] & SM[k*AW +: AW])) slv = k;
        end
        fire = (own >= 0) && s && (wd == TO);
        if (slv >= 0) begin
            e_cyc[slv] = c;
            e_stb[slv] = s && !fire;
            e_rdat = bus.s_dat_i[slv*DW +: DW];
            serr = s && !fire && bus.s_err_i[slv];
            sack = s && !fire && bus.s_ack_i[slv];
        end
        er = serr || fire || (dec && s);
        if (own >= 0) begin
            e_err[own] = er;
            e_ack[own] = sack && !er;
        end
        mc = c; ms = s; mslv = slv; mer = er; mack = sack && !er;
    endtask

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            own = -1; rr = 0; wd = 0; dec = 1'b0;
        end else begin
            model_eval();
            dec = (own >= 0) && mc && ms && (mslv < 0) && !dec;
            wd = ((own >= 0) && ms && !mack && !mer) ? wd + 1 : 0;
            if (own < 0) begin
                for (int i = 0; i < NM; i++)
                    if (own < 0 && bus.m_cyc_i[(rr + i) % NM]) own = (rr + i) % NM;
            end else if (!mc) begin
                rr = (own + 1) % NM;
                own = -1;
            end
        end
    end

    always @(negedge clk) begin
        model_eval();
        chk("grant", bus.grant_o, e_grant);
        chk("s_cyc", bus.s_cyc_o, e_cyc);
        chk("s_stb", bus.s_stb_o, e_stb);
        chk("s_we", bus.s_we_o, e_we);
        chk("s_sel", bus.s_sel_o, e_sel);
        chk("s_adr", bus.s_adr_o, e_adr);
        chk("s_dat", bus.s_dat_o, e_wdat);
        chk("m_ack", bus.m_ack_o, e_ack);
        chk("m_err", bus.m_err_o, e_err);
        chk("m_dat", bus.m_dat_o, e_rdat);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mset(input int i, input bit c, input bit s, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
        bus.m_cyc_i[i] = c;
        bus.m_stb_i[i] = s;
        bus.m_we_i[i] = we;
        bus.m_sel_i[i*SW +: SW] = SW'($urandom_range(1, 15));
        bus.m_adr_i[i*AW +: AW] = a;
        bus.m_dat_i[i*DW +: DW] = d;
    endtask

    function automatic logic [31:0] rnd_adr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {16'h0000, r[15:2], 2'b00};
            1: return {16'h0001, r[15:2], 2'b00};
            2: return {16'h0002, r[15:2], 2'b00};
            3: return {16'h0003, r[15:2], 2'b00};
            4: return 32'h8000_0000;
            default: return r;
        endcase
    endfunction

    int          done[NM];
    bit          got[NM];
    int          beats[NM];
    bit          resp[NM];
    logic [11:0] order;
    int          ngrants;
    int          direct;
    logic [NM-1:0] prev_g;

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_sel_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.s_dat_i = '0; bus.s_ack_i = '0; bus.s_err_i = '0;

        @(negedge clk);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_s_cyc", bus.s_cyc_o, 0);
        chk("rst_m_dat", bus.m_dat_o, 0);
        tick(); rst_i = 1'b1;

        // M0 read from RAM, slave acks two cycles later.
        tick(); mset(0, 1, 1, 0, 32'h0000_0010, 0);
        @(negedge clk); chk("t1_grant_pre", bus.grant_o, 2'b00);
        tick(); @(negedge clk);
        chk("t1_grant", bus.grant_o, 2'b01);
        chk("t1_s_stb", bus.s_stb_o, 3'b001);
        tick(); tick();
        bus.s_ack_i = 3'b001; bus.s_dat_i[31:0] = 32'hCAFE_0010;
        @(negedge clk);
        chk("t1_ack", bus.m_ack_o, 2'b01);
        chk("t1_dat", bus.m_dat_o, 32'hCAFE_0010);
        tick(); bus.s_ack_i = '0; mset(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_i = 1'b0; tick(); rst_i = 1'b1; tick();

        // Two masters contend, three single-beat cycles each.
        bus.s_ack_i = 3'b111;
        mset(0, 1, 1, 0, 32'h0000_0020, 0);
        mset(1, 1, 1, 1, 32'h0001_0004, 32'h55);
        done[0] = 0; done[1] = 0; order = '0; ngrants = 0; direct = 0; prev_g = '0;
        for (int n = 0; n < 200 && !(done[0] == 3 && done[1] == 3 && bus.m_cyc_i == 0); n++) begin
            @(negedge clk);
            for (int i = 0; i < NM; i++) got[i] = bus.m_ack_o[i];
            if (bus.grant_o != 0 && bus.grant_o != prev_g) begin
                order = {order[9:0], bus.grant_o};
                ngrants++;
                if (prev_g != 0) direct++;
            end
            prev_g = bus.grant_o;
            tick();
            for (int i = 0; i < NM; i++) begin
                if (got[i]) begin
                    done[i]++;
                    bus.m_cyc_i[i] = 1'b0; bus.m_stb_i[i] = 1'b0;
                end else if (!bus.m_cyc_i[i] && done[i] < 3) begin
                    bus.m_cyc_i[i] = 1'b1; bus.m_stb_i[i] = 1'b1;
                end
            end
        end
        chk("t2_ngrants", ngrants, 6);
        chk("t2_order", order, 12'h666);
        chk("t2_no_idle_gap", direct, 0);
        bus.s_ack_i = '0;
        repeat (2) tick();

        // M1 write to an undecoded address.
        mset(1, 1, 1, 1, 32'h8000_0000, 32'h1234);
        tick(); @(negedge clk);
        chk("t3_s_stb_c1", bus.s_stb_o, 3'b000);
        chk("t3_err_c1", bus.m_err_o, 2'b00);
        tick(); @(negedge clk);
        chk("t3_err_c2", bus.m_err_o, 2'b10);
        chk("t3_ack_c2", bus.m_ack_o, 2'b00);
        chk("t3_s_stb_c2", bus.s_stb_o, 3'b000);
        tick(); @(negedge clk);
        chk("t3_err_c3", bus.m_err_o, 2'b00);
        tick(); @(negedge clk);
        chk("t3_err_c4", bus.m_err_o, 2'b10);
        tick(); mset(1, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // GPIO never acks; watchdog fires after TO cycles of strobe.
        mset(0, 1, 1, 0, 32'h0001_0000, 0);
        for (int c = 1; c <= 5; c++) begin
            tick(); @(negedge clk);
            if (c < 5) begin
                chk("t4_err_wait", bus.m_err_o, 2'b00);
                chk("t4_stb_wait", bus.s_stb_o, 3'b010);
            end else begin
                chk("t4_err_fire", bus.m_err_o, 2'b01);
                chk("t4_stb_fire", bus.s_stb_o, 3'b000);
                chk("t4_cyc_fire", bus.s_cyc_o, 3'b010);
            end
        end
        tick(); mset(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Simultaneous ack and err from the slave.
        mset(1, 1, 1, 0, 32'h0002_0000, 0);
        bus.s_ack_i = 3'b100; bus.s_err_i = 3'b100;
        tick(); @(negedge clk);
        chk("t5_err", bus.m_err_o, 2'b10);
        chk("t5_ack", bus.m_ack_o, 2'b00);
        tick(); mset(1, 0, 0, 0, 0, 0); bus.s_ack_i = '0; bus.s_err_i = '0;
        repeat (2) tick();

        // Advance rr past M0, then reset asynchronously while M0 owns the bus.
        bus.s_ack_i = 3'b001;
        mset(0, 1, 1, 0, 32'h0000_0040, 0);
        tick(); tick(); mset(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        mset(0, 1, 1, 0, 32'h0000_0044, 0);
        tick(); @(negedge clk);
        chk("t6_ack_before", bus.m_ack_o, 2'b01);
        @(posedge clk); #3; rst_i = 1'b0; #1;
        chk("t6_grant_async", bus.grant_o, 2'b00);
        chk("t6_s_cyc_async", bus.s_cyc_o, 3'b000);
        chk("t6_ack_async", bus.m_ack_o, 2'b00);
        mset(1, 1, 1, 0, 32'h0001_0008, 0);
        tick(); rst_i = 1'b1;
        tick(); @(negedge clk);
        chk("t6_grant_after", bus.grant_o, 2'b01);
        tick(); mset(0, 0, 0, 0, 0, 0); mset(1, 0, 0, 0, 0, 0); bus.s_ack_i = '0;
        repeat (3) tick();

        // Randomized traffic checked cycle by cycle against the model.
        beats[0] = 0; beats[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < NM; i++) resp[i] = bus.m_ack_o[i] | bus.m_err_o[i];
            tick();
            for (int k = 0; k < NS; k++) begin
                bus.s_ack_i[k] = ($urandom_range(0, 2) == 0);
                bus.s_err_i[k] = ($urandom_range(0, 15) == 0);
                bus.s_dat_i[k*DW +: DW] = $urandom;
            end
            for (int i = 0; i < NM; i++) begin
                if (bus.m_cyc_i[i]) begin
                    if (resp[i]) begin
                        beats[i]--;
                        if (beats[i] <= 0) mset(i, 0, 0, 0, 0, 0);
                        else mset(i, 1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rnd_adr(), $urandom);
                    end else if (!bus.m_stb_i[i]) begin
                        bus.m_stb_i[i] = 1'b1;
                    end else if ($urandom_range(0, 39) == 0) begin
                        mset(i, 0, 0, 0, 0, 0);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    beats[i] = $urandom_range(1, 3);
                    mset(i, 1, 1, 1'($urandom_range(0, 1)), rnd_adr(), $urandom);
                end
            end
        end
        mset(0, 0, 0, 0, 0, 0); mset(1, 0, 0, 0, 0, 0);
        bus.s_ack_i = '0; bus.s_err_i = '0;
        repeat (3) tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
